// File: rtl/kv_slot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kv_slot_pkg
// Description : Shared types for the key/value slot store front-end.
//               op_e     - request opcode (GET/SET/DEL/RSVD)
//               status_e - response status (OK/MISS/FULL/ERR)
//               state_e  - write controller FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package kv_slot_pkg;

  typedef enum logic [1:0] {
    OP_GET  = 2'd0,
    OP_SET  = 2'd1,
    OP_DEL  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_MISS = 2'd1,
    ST_FULL = 2'd2,
    ST_ERR  = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

endpackage : kv_slot_pkg
`default_nettype wire

// File: rtl/kv_first_free_enc.sv
`default_nettype none
// ============================================================================
// Module      : kv_first_free_enc
// Description : Combinational lowest-index priority encoder.
// Ports       : i_req   [N-1:0]     candidate bits (1 = eligible)
//               o_idx   [IDX_W-1:0] index of lowest set bit (0 when none)
//               o_found             at least one bit of i_req is set
// Revision    : 1.0 - initial release
// ============================================================================
module kv_first_free_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule : kv_first_free_enc
`default_nettype wire

// File: rtl/kv_slot_write_controller.sv
`default_nettype none
// ============================================================================
// Module      : kv_slot_write_controller
// Description : Request front-end for the key/value slot store. Accepts
//               SET/GET/DEL over valid/ready, looks up the slot, drives
//               one-hot write strobes into the external key/value register
//               arrays and answers with a status. Owns the slot valid bitmap
//               and the occupancy count; the arrays hold raw bits only.
// Ports       : clk, rst_n                 clock, async active-low reset
//               req_valid/req_ready        request handshake
//               req_op/req_key/req_value   request payload
//               resp_valid/resp_ready      response handshake
//               resp_status/resp_value     response payload
//               slot_key_q/slot_val_q      packed array read data
//               slot_we                    one-hot array write strobe
//               slot_key_d/slot_val_d      shared array write data
//               occupancy                  number of valid slots
// Revision    : 1.0 - initial release
// ============================================================================
module kv_slot_write_controller
  import kv_slot_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int KEY_W     = 16,
  parameter int VAL_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     req_op,
  input  logic [KEY_W-1:0]               req_key,
  input  logic [VAL_W-1:0]               req_value,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [1:0]                     resp_status,
  output logic [VAL_W-1:0]               resp_value,
  input  logic [NUM_SLOTS*KEY_W-1:0]     slot_key_q,
  input  logic [NUM_SLOTS*VAL_W-1:0]     slot_val_q,
  output logic [NUM_SLOTS-1:0]           slot_we,
  output logic [KEY_W-1:0]               slot_key_d,
  output logic [VAL_W-1:0]               slot_val_d,
  output logic [$clog2(NUM_SLOTS):0]     occupancy
);

  localparam int c_IDX_W = $clog2(NUM_SLOTS);
  localparam int c_OCC_W = c_IDX_W + 1;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e                 r_state;
  op_e                    r_op;
  logic [KEY_W-1:0]       r_key;
  logic [VAL_W-1:0]       r_value;
  logic [NUM_SLOTS-1:0]   r_valid;
  logic [c_OCC_W-1:0]     r_occ;
  logic [NUM_SLOTS-1:0]   r_slot_we;
  logic [KEY_W-1:0]       r_key_d;
  logic [VAL_W-1:0]       r_val_d;
  status_e                r_resp_status;
  logic [VAL_W-1:0]       r_resp_value;

  // --------------------------------------------------------------------------
  // Lookup: key compare against every valid slot, lowest hit wins
  // --------------------------------------------------------------------------
  logic [NUM_SLOTS-1:0]   w_hit_vec;
  logic                   w_hit;
  logic [c_IDX_W-1:0]     w_hit_idx;
  logic [VAL_W-1:0]       w_hit_val;
  logic [c_IDX_W-1:0]     w_free_idx;
  logic                   w_free_found;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_cmp
    assign w_hit_vec[gi] = r_valid[gi] && (slot_key_q[gi*KEY_W +: KEY_W] == r_key);
  end

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = c_IDX_W'(i);
      end
    end
  end

  assign w_hit_val = slot_val_q[w_hit_idx*VAL_W +: VAL_W];

  kv_first_free_enc #(
    .N     (NUM_SLOTS),
    .IDX_W (c_IDX_W)
  ) u_free_enc (
    .i_req   (~r_valid),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  state_e                 w_state_nxt;
  logic                   w_do_write;
  logic [c_IDX_W-1:0]     w_widx;
  logic                   w_alloc;
  logic                   w_release;
  status_e                w_status;
  logic [VAL_W-1:0]       w_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and lookup decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_do_write  = 1'b0;
    w_widx      = w_hit_idx;
    w_alloc     = 1'b0;
    w_release   = 1'b0;
    w_status    = ST_OK;
    w_value     = '0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        w_state_nxt = S_RESP;
        case (r_op)
          OP_GET: begin
            if (w_hit) begin
              w_value = w_hit_val;
            end else begin
              w_status = ST_MISS;
            end
          end
          OP_SET: begin
            // Hit is checked first so a key can never occupy two slots.
            if (w_hit) begin
              w_do_write  = 1'b1;
              w_state_nxt = S_WRITE;
            end else if (w_free_found) begin
              w_do_write  = 1'b1;
              w_widx      = w_free_idx;
              w_alloc     = 1'b1;
              w_state_nxt = S_WRITE;
            end else begin
              w_status = ST_FULL;
            end
          end
          OP_DEL: begin
            // Deletion only drops the valid bit; array contents go stale.
            if (w_hit) begin
              w_release = 1'b1;
            end else begin
              w_status = ST_MISS;
            end
          end
          default: begin
            w_status = ST_ERR;
          end
        endcase
      end
      S_WRITE: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op          <= OP_GET;
      r_key         <= '0;
      r_value       <= '0;
      r_valid       <= '0;
      r_occ         <= '0;
      r_slot_we     <= '0;
      r_key_d       <= '0;
      r_val_d       <= '0;
      r_resp_status <= ST_OK;
      r_resp_value  <= '0;
    end else begin
      if ((r_state == S_IDLE) && req_valid) begin
        r_op    <= op_e'(req_op);
        r_key   <= req_key;
        r_value <= req_value;
      end

      // Strobe is high for exactly the WRITE cycle so the arrays see one
      // falling edge with it asserted; write data stays put afterwards.
      r_slot_we <= '0;
      if (w_do_write) begin
        r_slot_we <= NUM_SLOTS'(1) << w_widx;
        r_key_d   <= r_key;
        r_val_d   <= r_value;
      end

      if (w_alloc) begin
        r_valid[w_widx] <= 1'b1;
        r_occ           <= r_occ + c_OCC_W'(1);
      end
      if (w_release) begin
        r_valid[w_hit_idx] <= 1'b0;
        r_occ              <= r_occ - c_OCC_W'(1);
      end

      if ((r_state == S_LOOKUP) && !w_do_write) begin
        r_resp_status <= w_status;
        r_resp_value  <= w_value;
      end else if (r_state == S_WRITE) begin
        r_resp_status <= ST_OK;
        r_resp_value  <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_RESP);
  assign resp_status = r_resp_status;
  assign resp_value  = r_resp_value;
  assign slot_we     = r_slot_we;
  assign slot_key_d  = r_key_d;
  assign slot_val_d  = r_val_d;
  assign occupancy   = r_occ;

endmodule : kv_slot_write_controller
`default_nettype wire

// File: tb/tb_kv_slot_write_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_kv_slot_write_controller
// Description : Self-checking bench for kv_slot_write_controller. Emulates
//               the negedge-capture key/value arrays and keeps a slot-level
//               reference model of the store.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kv_slot_write_controller;

  localparam int NS = 8;
  localparam int KW = 16;
  localparam int VW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = 2'd0;
  logic [KW-1:0]     req_key = '0;
  logic [VW-1:0]     req_value = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [1:0]        resp_status;
  logic [VW-1:0]     resp_value;
  logic [NS*KW-1:0]  arr_key = '0;
  logic [NS*VW-1:0]  arr_val = '0;
  logic [NS-1:0]     slot_we;
  logic [KW-1:0]     slot_key_d;
  logic [VW-1:0]     slot_val_d;
  logic [3:0]        occupancy;

  always #5 clk = ~clk;

  kv_slot_write_controller #(
    .NUM_SLOTS (NS),
    .KEY_W     (KW),
    .VAL_W     (VW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_key     (req_key),
    .req_value   (req_value),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_status (resp_status),
    .resp_value  (resp_value),
    .slot_key_q  (arr_key),
    .slot_val_q  (arr_val),
    .slot_we     (slot_we),
    .slot_key_d  (slot_key_d),
    .slot_val_d  (slot_val_d),
    .occupancy   (occupancy)
  );

  // External register arrays: capture on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (slot_we[i]) begin
        arr_key[i*KW +: KW] <= slot_key_d;
        arr_val[i*VW +: VW] <= slot_val_d;
      end
    end
  end

  // Reference model: slots filled lowest-free-first.
  bit            m_valid [NS];
  logic [KW-1:0] m_key   [NS];
  logic [VW-1:0] m_val   [NS];
  int            m_occ;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
    m_occ = 0;
  endtask

  // One full transaction; hold>0 keeps resp_ready low for that many cycles
  // while a stray request is offered.
  task automatic do_req(input int op, input logic [KW-1:0] key,
                        input logic [VW-1:0] val, input int hold);
    int            hit, free, exp_st, exp_lat, n, we_cycles;
    logic [VW-1:0] exp_v;
    logic [NS-1:0] exp_we, we_seen;
    hit = -1; free = -1;
    for (int i = 0; i < NS; i++) if (hit < 0 && m_valid[i] && m_key[i] == key) hit = i;
    for (int i = 0; i < NS; i++) if (free < 0 && !m_valid[i]) free = i;
    exp_v = '0; exp_we = '0; exp_lat = 2; exp_st = 0;
    case (op)
      0: if (hit >= 0) exp_v = m_val[hit]; else exp_st = 1;
      1: if (hit >= 0) begin
           exp_we = NS'(1) << hit; m_val[hit] = val; exp_lat = 3;
         end else if (free >= 0) begin
           exp_we = NS'(1) << free; m_valid[free] = 1'b1;
           m_key[free] = key; m_val[free] = val; m_occ++; exp_lat = 3;
         end else exp_st = 2;
      2: if (hit >= 0) begin m_valid[hit] = 1'b0; m_occ--; end else exp_st = 1;
      default: exp_st = 3;
    endcase

    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op[1:0]; req_key = key; req_value = val;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1; we_cycles = 0; we_seen = '0;
    while (!resp_valid && n < 10) begin
      if (slot_we != '0) begin we_cycles++; we_seen |= slot_we; end
      @(posedge clk); #1;
      n++;
    end
    check("resp_valid", resp_valid, 1);
    check("latency", n, exp_lat);
    check("resp_status", resp_status, exp_st);
    check("resp_value", resp_value, exp_v);
    check("slot_we_mask", we_seen, exp_we);
    check("slot_we_cycles", we_cycles, (exp_we != '0) ? 1 : 0);
    check("slot_we_in_resp", slot_we, 0);
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1; req_op = 2'd1; req_key = 16'hBEEF; req_value = $urandom;
      @(posedge clk); #1;
      check("hold_resp_valid", resp_valid, 1);
      check("hold_status", resp_status, exp_st);
      check("hold_value", resp_value, exp_v);
      check("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    check("resp_done", resp_valid, 0);
    check("back_idle", req_ready, 1);
    check("occupancy", occupancy, m_occ);
  endtask

  initial begin
    int slot_a5;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_status", resp_status, 0);
    check("rst_resp_value", resp_value, 0);
    check("rst_slot_we", slot_we, 0);
    check("rst_key_d", slot_key_d, 0);
    check("rst_val_d", slot_val_d, 0);
    check("rst_occupancy", occupancy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1, 16'h00A5, 32'hDEADBEEF, 0);
    do_req(0, 16'h00A5, '0, 0);
    do_req(0, 16'h1234, '0, 0);
    do_req(1, 16'h00A5, 32'h11111111, 0);
    do_req(0, 16'h00A5, '0, 0);
    for (int i = 1; i < NS; i++) do_req(1, 16'h0100 + 16'(i), $urandom, 0);
    do_req(1, 16'h0F00, 32'h0BADF00D, 0);   // store full
    do_req(2, 16'h0103, '0, 0);             // frees slot 3
    do_req(1, 16'h0F00, 32'h0BADF00D, 0);   // lands in slot 3
    do_req(3, 16'h00A5, '0, 0);             // reserved op
    do_req(0, 16'h00A5, '0, 5);             // back-pressured response

    // Reset in the middle of an overwrite of key 0x00A5.
    slot_a5 = -1;
    for (int i = 0; i < NS; i++) if (slot_a5 < 0 && m_valid[i] && m_key[i] == 16'h00A5) slot_a5 = i;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_key = 16'h00A5; req_value = 32'h55555555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("we_before_rst", slot_we, NS'(1) << slot_a5);
    rst_n = 1'b0;
    #1;
    check("async_rst_we", slot_we, 0);
    check("async_rst_occ", occupancy, 0);
    check("async_rst_resp_valid", resp_valid, 0);
    check("async_rst_req_ready", req_ready, 1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 16'h00A5, '0, 0);

    for (int t = 0; t < 300; t++) begin
      int r, op;
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 1 : (r < 7) ? 0 : (r < 9) ? 2 : 3;
      do_req(op, 16'h0200 + 16'($urandom_range(0, 11)), $urandom,
             ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_kv_slot_write_controller
`default_nettype wire
